dmem_store_buffer: RTL and testbench

- Posted-write buffer between the CPU data port and the single-port data memory (combinational read, byte-enabled write on posedge clk).
- Accepts CPU stores into a small FIFO and drains them to dmem in idle read cycles.
- Forwards buffered bytes to CPU loads so memory stays coherent with program order.
- Raises `stall` when a store cannot be accepted or a load cannot be served; `empty` tells the bench all stores have reached dmem before the final dump.

---
 rtl/dmem_store_buffer.sv | 113 +++++++++++
 tb/tb_dmem_store_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the CPU data port and a single-port data memory.
// Stores queue in a small FIFO, drain in cycles without a load, and forward to loads.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    input  logic [3:0]    dwe,
    input  logic          dre,
    output logic [DW-1:0] drdata,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] m_daddr,
    output logic [DW-1:0] m_dwdata,
    output logic [3:0]    m_dwe,
    input  logic [DW-1:0] m_drdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - 2;

    logic [WW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [3:0]    mask_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic          full;
    logic          store_req;
    logic          load_go;
    logic          load_stall;
    logic          drain;
    logic          push;
    logic [DW-1:0] fwd;
    logic [PW-1:0] fwd_idx;

    assign full       = (count_q == (PW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign store_req  = |dwe;
    assign load_go    = dre && !full;
    assign load_stall = dre && full;
    // A load on a full buffer yields the port to the drain so the buffer always makes progress.
    assign drain      = reset && !empty && !load_go;
    // A stalled request is held by the CPU as a whole, so a stalled load also blocks its store.
    assign push       = reset && store_req && !load_stall && (!full || drain);
    assign stall      = reset && (load_stall || (store_req && !push));

    assign m_daddr  = drain ? {addr_q[head_q], 2'b00} : daddr;
    assign m_dwdata = drain ? data_q[head_q] : dwdata;
    assign m_dwe    = drain ? mask_q[head_q] : 4'h0;
    assign drdata   = (reset && load_go) ? fwd : m_drdata;

    // Walk entries oldest to youngest so the youngest matching store wins per byte.
    always_comb begin
        fwd     = m_drdata;
        fwd_idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if (((PW+1)'(k) < count_q) && (addr_q[fwd_idx] == daddr[AW-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_q[fwd_idx][b]) begin
                        fwd[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push, drain})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload carries no reset; validity comes solely from head and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= daddr[AW-1:2];
            data_q[tail_q] <= dwdata;
            mask_q[tail_q] <= dwe;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios plus randomized traffic
// against a program-order memory view and a FIFO of pending stores.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic        dre;
    logic [31:0] drdata;
    logic        stall;
    logic        empty;
    logic [31:0] m_daddr;
    logic [31:0] m_dwdata;
    logic [3:0]  m_dwe;
    logic [31:0] m_drdata;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
        logic [3:0]  mask;
    } st_t;
    st_t sq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        obs_stall, obs_empty;
    logic [3:0]  obs_mdwe;
    logic [31:0] obs_mdaddr, obs_mdwdata, obs_rd;
    logic        exp_stall, exp_empty, exp_load, exp_drain, exp_push;
    logic [3:0]  exp_mdwe;
    logic [31:0] exp_mdaddr, exp_mdwdata, exp_rd;

    assign m_drdata = mem[m_daddr[7:2]];

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .dre      (dre),
        .drdata   (drdata),
        .stall    (stall),
        .empty    (empty),
        .m_daddr  (m_daddr),
        .m_dwdata (m_dwdata),
        .m_dwe    (m_dwe),
        .m_drdata (m_drdata)
    );

    // One clock of CPU traffic; called at posedge+1. Captures observed and model-expected
    // values before the edge, then performs the dmem write and advances the model.
    task automatic step(input logic [3:0] we, input logic re, input logic [31:0] a,
                        input logic [31:0] d);
        int  n;
        st_t e;
        dwe = we; dre = re; daddr = a; dwdata = d;
        @(negedge clk);
        n           = reset ? sq.size() : 0;
        exp_empty   = (n == 0);
        exp_load    = re && (n < DEPTH);
        exp_stall   = reset && re && (n == DEPTH);
        exp_drain   = reset && (n > 0) && !exp_load;
        exp_push    = reset && (we != 4'h0) && !exp_stall;
        exp_mdwe    = 4'h0;
        exp_mdaddr  = a;
        exp_mdwdata = 32'h0;
        if (exp_drain) begin
            exp_mdwe    = sq[0].mask;
            exp_mdaddr  = {sq[0].word, 2'b00};
            exp_mdwdata = sq[0].data;
        end
        exp_rd      = ref_mem[a[7:2]];
        obs_stall   = stall;
        obs_empty   = empty;
        obs_mdwe    = m_dwe;
        obs_mdaddr  = m_daddr;
        obs_mdwdata = m_dwdata;
        obs_rd      = drdata;
        @(posedge clk);
        for (int b = 0; b < 4; b++)
            if (obs_mdwe[b]) mem[obs_mdaddr[7:2]][8*b +: 8] = obs_mdwdata[8*b +: 8];
        if (exp_drain) void'(sq.pop_front());
        if (exp_push) begin
            e.word = a[31:2]; e.data = d; e.mask = we;
            sq.push_back(e);
            for (int b = 0; b < 4; b++)
                if (we[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
        end
        #1;
        cyc++;
    endtask

    task automatic drain_all(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * DEPTH + 4; i++) begin
            step(4'h0, 1'b0, 32'h0, 32'h0);
            if (obs_empty) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        dwe = 4'hF; daddr = 32'h10; dre = 1'b0; dwdata = 32'h12345678;
        #2;
        checks++;
        if ({m_dwe, stall, empty} !== {4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got m_dwe=%h stall=%b empty=%b want 0 0 1", m_dwe, stall, empty);
        end
        checks++;
        if (m_daddr !== 32'h10 || drdata !== mem[4]) begin
            errors++;
            $display("FAIL reset_passthru got m_daddr=%h drdata=%h want 10 %h", m_daddr, drdata, mem[4]);
        end
        @(posedge clk); #3;
        reset = 1'b1;
        dwe = 4'h0;
        @(posedge clk); #1;
        step(4'h0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_empty !== 1'b1 || obs_mdwe !== 4'h0) begin
            errors++;
            $display("FAIL reset_release got empty=%b m_dwe=%h want 1 0", obs_empty, obs_mdwe);
        end
    endtask

    task automatic test_single_store;
        step(4'hF, 1'b0, 32'h20, 32'hDEADBEEF);
        checks++;
        if (obs_stall !== 1'b0 || obs_mdwe !== 4'h0) begin
            errors++;
            $display("FAIL single_accept got stall=%b m_dwe=%h want 0 0", obs_stall, obs_mdwe);
        end
        step(4'h0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({obs_mdwe, obs_mdaddr, obs_mdwdata} !== {4'hF, 32'h20, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_drain got %h %h %h want f 00000020 deadbeef", obs_mdwe, obs_mdaddr, obs_mdwdata);
        end
        step(4'h0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_empty !== 1'b1 || mem[8] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_done got empty=%b mem8=%h want 1 deadbeef", obs_empty, mem[8]);
        end
    endtask

    task automatic test_byte_merge;
        bit ok;
        mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
        step(4'h1, 1'b0, 32'h40, 32'h000000AA);
        step(4'h2, 1'b0, 32'h40, 32'h0000BB00);
        step(4'h0, 1'b1, 32'h40, 32'h0);
        checks++;
        if (obs_rd !== 32'h1122BBAA || obs_stall !== 1'b0 || obs_mdwe !== 4'h0) begin
            errors++;
            $display("FAIL merge_load got rd=%h stall=%b m_dwe=%h want 1122bbaa 0 0", obs_rd, obs_stall, obs_mdwe);
        end
        drain_all(ok);
        checks++;
        if (!ok || mem[16] !== 32'h1122BBAA) begin
            errors++;
            $display("FAIL merge_final got drained=%0d mem=%h want 1 1122bbaa", ok, mem[16]);
        end
    endtask

    task automatic test_full_wrap;
        bit ok;
        for (int i = 1; i <= 4; i++) begin
            step(4'hF, 1'b1, 32'(4 * (i - 1)), 32'(i));
            checks++;
            if (obs_stall !== 1'b0 || obs_rd !== exp_rd) begin
                errors++;
                $display("FAIL fill_%0d got stall=%b rd=%h want 0 %h", i, obs_stall, obs_rd, exp_rd);
            end
        end
        step(4'hF, 1'b1, 32'h10, 32'h5);
        checks++;
        if ({obs_stall, obs_mdwe, obs_mdaddr, obs_mdwdata} !== {1'b1, 4'hF, 32'h0, 32'h1}) begin
            errors++;
            $display("FAIL full_stall got stall=%b %h %h %h want 1 f 0 1", obs_stall, obs_mdwe, obs_mdaddr, obs_mdwdata);
        end
        step(4'hF, 1'b1, 32'h10, 32'h5);
        checks++;
        if (obs_stall !== 1'b0 || obs_mdwe !== 4'h0) begin
            errors++;
            $display("FAIL full_retry got stall=%b m_dwe=%h want 0 0", obs_stall, obs_mdwe);
        end
        drain_all(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_drain got empty=0 want 1");
        end
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (mem[w] !== 32'(w + 1)) begin
                errors++;
                $display("FAIL wrap_word%0d got %h want %h", w, mem[w], w + 1);
            end
        end
    endtask

    task automatic test_same_addr;
        step(4'hF, 1'b0, 32'h8, 32'h1);
        step(4'h0, 1'b1, 32'h8, 32'h0);
        checks++;
        if (obs_rd !== 32'h1) begin
            errors++;
            $display("FAIL same_load got %h want 1", obs_rd);
        end
        step(4'hF, 1'b0, 32'h8, 32'h2);
        checks++;
        if (obs_mdwe !== 4'hF || obs_mdwdata !== 32'h1) begin
            errors++;
            $display("FAIL same_drain1 got %h %h want f 1", obs_mdwe, obs_mdwdata);
        end
        step(4'h0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_mdaddr !== 32'h8 || obs_mdwdata !== 32'h2) begin
            errors++;
            $display("FAIL same_drain2 got %h %h want 8 2", obs_mdaddr, obs_mdwdata);
        end
        step(4'h0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_empty !== 1'b1 || mem[2] !== 32'h2) begin
            errors++;
            $display("FAIL same_final got empty=%b mem=%h want 1 2", obs_empty, mem[2]);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] snap [3];
        step(4'hF, 1'b1, 32'h30, 32'hA1A1A1A1);
        step(4'hF, 1'b1, 32'h34, 32'hA2A2A2A2);
        step(4'hF, 1'b1, 32'h38, 32'hA3A3A3A3);
        for (int i = 0; i < 3; i++) snap[i] = mem[12 + i];
        dwe = 4'h0; dre = 1'b0; daddr = 32'h0;
        #2;
        checks++;
        if (m_dwe !== 4'hF || m_daddr !== 32'h30) begin
            errors++;
            $display("FAIL mid_drain got %h %h want f 30", m_dwe, m_daddr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({m_dwe, empty, stall} !== {4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset got m_dwe=%h empty=%b stall=%b want 0 1 0", m_dwe, empty, stall);
        end
        sq.delete();
        for (int w = 0; w < 64; w++) ref_mem[w] = mem[w];
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            step(4'h0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs_mdwe !== 4'h0 || obs_empty !== 1'b1) begin
                errors++;
                $display("FAIL mid_after%0d got m_dwe=%h empty=%b want 0 1", i, obs_mdwe, obs_empty);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[12 + i] !== snap[i]) begin
                errors++;
                $display("FAIL mid_mem%0d got %h want %h", i, mem[12 + i], snap[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [3:0]  we;
        logic        re;
        logic [31:0] a, d;
        bit          ok;
        we = 4'h0; re = 1'b0; a = 32'h80; d = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (i == 0 || !obs_stall) begin
                case ($urandom_range(0, 3))
                    0: begin we = 4'h0; re = 1'b0; end
                    1: begin we = 4'($urandom_range(1, 15)); re = 1'b0; end
                    2: begin we = 4'h0; re = 1'b1; end
                    default: begin we = 4'($urandom_range(1, 15)); re = 1'b1; end
                endcase
                a = 32'h80 + 32'(4 * $urandom_range(0, 7));
                d = $urandom;
            end
            step(we, re, a, d);
            checks++;
            if ({obs_stall, obs_empty, obs_mdwe, obs_mdaddr} !== {exp_stall, exp_empty, exp_mdwe, exp_mdaddr}) begin
                errors++;
                $display("FAIL rand_ctl cyc %0d got %b %b %h %h want %b %b %h %h", cyc, obs_stall, obs_empty,
                         obs_mdwe, obs_mdaddr, exp_stall, exp_empty, exp_mdwe, exp_mdaddr);
            end
            if (exp_drain) begin
                checks++;
                if (obs_mdwdata !== exp_mdwdata) begin
                    errors++;
                    $display("FAIL rand_wdata cyc %0d got %h want %h", cyc, obs_mdwdata, exp_mdwdata);
                end
            end
            if (exp_load) begin
                checks++;
                if (obs_rd !== exp_rd) begin
                    errors++;
                    $display("FAIL rand_load cyc %0d addr %h got %h want %h", cyc, a, obs_rd, exp_rd);
                end
            end
        end
        drain_all(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rand_drain got empty=0 want 1");
        end
        for (int w = 0; w < 64; w++) begin
            checks++;
            if (mem[w] !== ref_mem[w]) begin
                errors++;
                $display("FAIL rand_mem word %0d got %h want %h", w, mem[w], ref_mem[w]);
            end
        end
    endtask

    initial begin
        reset = 1'b0; dwe = 4'h0; dre = 1'b0; daddr = 32'h0; dwdata = 32'h0;
        for (int w = 0; w < 64; w++) begin
            mem[w]     = $urandom;
            ref_mem[w] = mem[w];
        end
        test_reset;
        test_single_store;
        test_byte_merge;
        test_full_wrap;
        test_same_addr;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
